// File: rtl/asym_stream_fifo_pkg.sv
// asym_stream_fifo_pkg: shared geometry helpers for the asymmetric stream FIFO.
// Optional macro ASYM_STREAM_FIFO_MSB_FIRST_EN reverses the sub-word granule
// order; slice_lo() is the only place that reacts to it.
package asym_stream_fifo_pkg;

    // Granule width: the narrower of the two bus widths.
    function automatic int gran_w(input int dw, input int dr);
        return (dw < dr) ? dw : dr;
    endfunction

    // Granules per write word.
    function automatic int wr_ratio(input int dw, input int dr);
        return dw / gran_w(dw, dr);
    endfunction

    // Granules per read word.
    function automatic int rr_ratio(input int dw, input int dr);
        return dr / gran_w(dw, dr);
    endfunction

    // Array granules: capacity in write words times granules per write word.
    function automatic int num_gran(input int dw, input int dr, input int depth_w);
        return (1 << depth_w) * wr_ratio(dw, dr);
    endfunction

    // Pointer width: one extra MSB so full and empty are distinguishable.
    function automatic int ptr_w(input int dw, input int dr, input int depth_w);
        return $clog2(num_gran(dw, dr, depth_w)) + 1;
    endfunction

    // Level width: array granules plus the output register.
    function automatic int level_w(input int dw, input int dr, input int depth_w);
        return $clog2(num_gran(dw, dr, depth_w) + rr_ratio(dw, dr)) + 1;
    endfunction

    // Array address width.
    function automatic int addr_w(input int ng);
        return (ng > 1) ? $clog2(ng) : 1;
    endfunction

    function automatic bit is_pow2(input int r);
        return (r > 0) && ((r & (r - 1)) == 0);
    endfunction

    // Low bit of granule k inside an n-granule word of g-bit granules.
    function automatic int slice_lo(input int k, input int n, input int g);
`ifdef ASYM_STREAM_FIFO_MSB_FIRST_EN
        return g * (n - 1 - k);
`else
        return (n > k) ? g * k : 0;
`endif
    endfunction

endpackage

// File: rtl/asym_stream_fifo_if.sv
// asym_stream_fifo_if: write/read handshake bundle of the asymmetric FIFO.
// slave = FIFO side, master = producer/consumer side.
interface asym_stream_fifo_if #(
    parameter int DATA_W  = 8,
    parameter int DATA_R  = 8,
    parameter int DEPTH_W = 8
);
    import asym_stream_fifo_pkg::*;

    localparam int LEVEL_W = level_w(DATA_W, DATA_R, DEPTH_W);

    logic               i_flush;
    logic               i_wvalid;
    logic               o_wready;
    logic [DATA_W-1:0]  i_wdata;
    logic               o_rvalid;
    logic               i_rready;
    logic [DATA_R-1:0]  o_rdata;
    logic [LEVEL_W-1:0] o_level;
    logic               o_wr_drop;

    modport slave (
        input  i_flush, i_wvalid, i_wdata, i_rready,
        output o_wready, o_rvalid, o_rdata, o_level, o_wr_drop
    );

    modport master (
        output i_flush, i_wvalid, i_wdata, i_rready,
        input  o_wready, o_rvalid, o_rdata, o_level, o_wr_drop
    );

endinterface

// File: rtl/asym_stream_fifo_ram.sv
// asym_granule_ram: NG x G storage; writes WR consecutive granules and reads
// RR consecutive granules, both wrapping modulo NG. Contents are not reset.
// Granule placement inside the words follows ASYM_STREAM_FIFO_MSB_FIRST_EN
// through slice_lo().
module asym_granule_ram
    import asym_stream_fifo_pkg::*;
#(
    parameter int G  = 8,
    parameter int WR = 1,
    parameter int RR = 1,
    parameter int NG = 256
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [addr_w(NG)-1:0]  waddr,
    input  logic [G*WR-1:0]        wdata,
    input  logic [addr_w(NG)-1:0]  raddr,
    output logic [G*RR-1:0]        rdata
);
    localparam int AW = addr_w(NG);

    logic [G-1:0] mem [NG];

    // Scatter the write word into WR consecutive granule slots.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < WR; k++) begin
                mem[waddr + AW'(k)] <= wdata[slice_lo(k, WR, G) +: G];
            end
        end
    end

    // Gather RR consecutive granules into one read word.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < RR; k++) begin
            rdata[slice_lo(k, RR, G) +: G] = mem[raddr + AW'(k)];
        end
    end

endmodule

// File: rtl/asym_stream_fifo.sv
// asym_stream_fifo: synchronous FIFO converting between power-of-two related
// write/read widths. Storage is granule addressed; pointers, handshake and
// the registered output stage live here, the array in asym_granule_ram.
// Optional macro ASYM_STREAM_FIFO_MSB_FIRST_EN: most significant granule first.
module asym_stream_fifo
    import asym_stream_fifo_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DATA_R  = 8,
    parameter int DEPTH_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    asym_stream_fifo_if.slave bus
);
    localparam int RAM_NUM_W = 1 << DEPTH_W;
    localparam int G         = gran_w(DATA_W, DATA_R);
    localparam int WR        = wr_ratio(DATA_W, DATA_R);
    localparam int RR        = rr_ratio(DATA_W, DATA_R);
    localparam int NG        = RAM_NUM_W * WR;
    localparam int PW        = ptr_w(DATA_W, DATA_R, DEPTH_W);
    localparam int LW        = level_w(DATA_W, DATA_R, DEPTH_W);
    localparam int AW        = addr_w(NG);
    localparam int BIG       = (DATA_W > DATA_R) ? DATA_W : DATA_R;
    localparam int RATIO     = BIG / G;

    // Elaboration-time geometry checks.
    if ((BIG % G) != 0) begin : g_chk_mult
        $error("asym_stream_fifo: larger width %0d is not a multiple of %0d", BIG, G);
    end
    if (!is_pow2(RATIO)) begin : g_chk_pow2
        $error("asym_stream_fifo: width ratio %0d is not a power of two", RATIO);
    end
    if (NG < RR) begin : g_chk_depth
        $error("asym_stream_fifo: %0d granules cannot hold one read word of %0d", NG, RR);
    end

    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [PW-1:0]     used;
    logic [PW-1:0]     free_g;
    logic              wr_ok;
    logic              wr_fire;
    logic              rd_load;
    logic [DATA_R-1:0] ram_rdata;
    logic              vld_p0;
    logic [DATA_R-1:0] rdata_p0;
    logic              wr_drop_p0;

    // Occupancy and acceptance come from registered pointers only.
    assign used    = wptr - rptr;
    assign free_g  = PW'(NG) - used;
    assign wr_ok   = free_g >= PW'(WR);
    assign wr_fire = bus.i_wvalid & wr_ok & ~bus.i_flush;
    assign rd_load = (~vld_p0 | bus.i_rready) & (used >= PW'(RR));

    asym_granule_ram #(
        .G  (G),
        .WR (WR),
        .RR (RR),
        .NG (NG)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wptr[AW-1:0]),
        .wdata (bus.i_wdata),
        .raddr (rptr[AW-1:0]),
        .rdata (ram_rdata)
    );

    // Pointer advance, output register load/drain and overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            vld_p0     <= 1'b0;
            rdata_p0   <= '0;
            wr_drop_p0 <= 1'b0;
        end else if (bus.i_flush) begin
            // Flush wins over a same-cycle write and read; the write is not a drop.
            wptr       <= '0;
            rptr       <= '0;
            vld_p0     <= 1'b0;
            wr_drop_p0 <= 1'b0;
        end else begin
            wr_drop_p0 <= bus.i_wvalid & ~wr_ok;
            if (wr_fire) begin
                wptr <= wptr + PW'(WR);
            end
            // ---- output stage p0: a read word appears only when complete ----
            if (rd_load) begin
                rdata_p0 <= ram_rdata;
                rptr     <= rptr + PW'(RR);
                vld_p0   <= 1'b1;
            end else if (bus.i_rready) begin
                vld_p0   <= 1'b0;
            end
        end
    end

    assign bus.o_wready  = wr_ok;
    assign bus.o_rvalid  = vld_p0;
    assign bus.o_rdata   = rdata_p0;
    assign bus.o_wr_drop = wr_drop_p0;
    assign bus.o_level   = LW'(used) + (vld_p0 ? LW'(RR) : LW'(0));

endmodule

// File: tb/tb_asym_stream_fifo.sv
// tb_asym_stream_fifo: three FIFO geometries (32->8, 8->32, 16->64) driven by
// directed scenarios and randomized traffic against a granule-queue model.
module tb_asym_stream_fifo;

`ifdef ASYM_STREAM_FIFO_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    asym_stream_fifo_if #(.DATA_W(32), .DATA_R(8),  .DEPTH_W(2)) if_a ();
    asym_stream_fifo_if #(.DATA_W(8),  .DATA_R(32), .DEPTH_W(2)) if_b ();
    asym_stream_fifo_if #(.DATA_W(16), .DATA_R(64), .DEPTH_W(3)) if_c ();

    asym_stream_fifo #(.DATA_W(32), .DATA_R(8),  .DEPTH_W(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    asym_stream_fifo #(.DATA_W(8),  .DATA_R(32), .DEPTH_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    asym_stream_fifo #(.DATA_W(16), .DATA_R(64), .DEPTH_W(3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of stored granules plus the held output word.
    logic [63:0] m_q[$];
    bit          m_held;
    logic [63:0] m_word;
    bit          m_drop;
    int          m_g, m_wr, m_rr, m_ng;

    function automatic void m_clear(input int sel);
        int dw, dr, dp;
        case (sel)
            0:       begin dw = 32; dr = 8;  dp = 2; end
            1:       begin dw = 8;  dr = 32; dp = 2; end
            default: begin dw = 16; dr = 64; dp = 3; end
        endcase
        m_g  = (dw < dr) ? dw : dr;
        m_wr = dw / m_g;
        m_rr = dr / m_g;
        m_ng = (1 << dp) * m_wr;
        m_q.delete();
        m_held = 1'b0;
        m_word = '0;
        m_drop = 1'b0;
    endfunction

    function automatic bit m_wready();
        return (m_ng - m_q.size()) >= m_wr;
    endfunction

    function automatic int m_level();
        return m_q.size() + (m_held ? m_rr : 0);
    endfunction

    function automatic void m_step(input bit wv, input logic [63:0] wd, input bit rr);
        bit          acc;
        int          sh;
        logic [63:0] gr;
        logic [63:0] mask;
        mask   = (64'd1 << m_g) - 64'd1;
        acc    = wv && m_wready();
        m_drop = wv && !m_wready();
        if ((!m_held || rr) && (m_q.size() >= m_rr)) begin
            m_word = '0;
            for (int k = 0; k < m_rr; k++) begin
                gr = m_q.pop_front();
                sh = MSB_FIRST ? m_g * (m_rr - 1 - k) : m_g * k;
                m_word = m_word | (gr << sh);
            end
            m_held = 1'b1;
        end else if (rr) begin
            m_held = 1'b0;
        end
        if (acc) begin
            for (int k = 0; k < m_wr; k++) begin
                sh = MSB_FIRST ? m_g * (m_wr - 1 - k) : m_g * k;
                m_q.push_back((wd >> sh) & mask);
            end
        end
    endfunction

    task automatic drive(input int sel, input bit wv, input logic [63:0] wd, input bit rr, input bit fl);
        case (sel)
            0: begin if_a.i_wvalid = wv; if_a.i_wdata = wd[31:0]; if_a.i_rready = rr; if_a.i_flush = fl; end
            1: begin if_b.i_wvalid = wv; if_b.i_wdata = wd[7:0];  if_b.i_rready = rr; if_b.i_flush = fl; end
            default: begin if_c.i_wvalid = wv; if_c.i_wdata = wd[15:0]; if_c.i_rready = rr; if_c.i_flush = fl; end
        endcase
    endtask

    task automatic sample(input int sel, output logic [63:0] lvl, output logic wrdy,
                          output logic rv, output logic [63:0] rd, output logic drop);
        case (sel)
            0: begin lvl = 64'(if_a.o_level); wrdy = if_a.o_wready; rv = if_a.o_rvalid; rd = 64'(if_a.o_rdata); drop = if_a.o_wr_drop; end
            1: begin lvl = 64'(if_b.o_level); wrdy = if_b.o_wready; rv = if_b.o_rvalid; rd = 64'(if_b.o_rdata); drop = if_b.o_wr_drop; end
            default: begin lvl = 64'(if_c.o_level); wrdy = if_c.o_wready; rv = if_c.o_rvalid; rd = 64'(if_c.o_rdata); drop = if_c.o_wr_drop; end
        endcase
    endtask

    task automatic test_reset();
        logic [63:0] lvl, rd;
        logic        wrdy, rv, drop;
        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            sample(s, lvl, wrdy, rv, rd, drop);
            n_cmp++; if (lvl !== 64'd0) begin n_bad++; $display("FAIL reset_level[%0d]: got %0h want 0", s, lvl); end
            n_cmp++; if (wrdy !== 1'b1) begin n_bad++; $display("FAIL reset_wready[%0d]: got %b want 1", s, wrdy); end
            n_cmp++; if (rv !== 1'b0)   begin n_bad++; $display("FAIL reset_rvalid[%0d]: got %b want 0", s, rv); end
            n_cmp++; if (rd !== 64'd0)  begin n_bad++; $display("FAIL reset_rdata[%0d]: got %0h want 0", s, rd); end
            n_cmp++; if (drop !== 1'b0) begin n_bad++; $display("FAIL reset_drop[%0d]: got %b want 0", s, drop); end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wide_to_narrow();
        logic [7:0] exp [4];
        if (MSB_FIRST) begin exp[0] = 8'h44; exp[1] = 8'h33; exp[2] = 8'h22; exp[3] = 8'h11; end
        else           begin exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44; end
        @(negedge clk);
        drive(0, 1'b1, 64'h44332211, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++; if (if_a.o_rvalid !== 1'b0) begin n_bad++; $display("FAIL w2n_latency: rvalid %b want 0", if_a.o_rvalid); end
        drive(0, 1'b0, 64'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (if_a.o_rvalid !== 1'b1 || if_a.o_rdata !== exp[i]) begin
                n_bad++; $display("FAIL w2n_word%0d: got v=%b d=%0h want v=1 d=%0h", i, if_a.o_rvalid, if_a.o_rdata, exp[i]);
            end
        end
        @(negedge clk);
        n_cmp++; if (if_a.o_rvalid !== 1'b0 || if_a.o_level !== 6'd0) begin
            n_bad++; $display("FAIL w2n_drained: v=%b level=%0d want v=0 level=0", if_a.o_rvalid, if_a.o_level);
        end
        drive(0, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic test_full_drop();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (if_a.o_wready !== 1'b1) begin n_bad++; $display("FAIL fill_wready%0d: got %b want 1", i, if_a.o_wready); end
            drive(0, 1'b1, 64'($urandom), 1'b0, 1'b0);
            @(negedge clk);
        end
        n_cmp++; if (if_a.o_wready !== 1'b0 || if_a.o_level !== 6'd16) begin
            n_bad++; $display("FAIL full_state: wready=%b level=%0d want wready=0 level=16", if_a.o_wready, if_a.o_level);
        end
        drive(0, 1'b1, 64'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (if_a.o_wr_drop !== 1'b1 || if_a.o_level !== 6'd16) begin
            n_bad++; $display("FAIL drop_pulse: drop=%b level=%0d want drop=1 level=16", if_a.o_wr_drop, if_a.o_level);
        end
        drive(0, 1'b0, 64'd0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (if_a.o_wr_drop !== 1'b0) begin n_bad++; $display("FAIL drop_one_cycle: got %b want 0", if_a.o_wr_drop); end
        drive(0, 1'b0, 64'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++; if (if_a.o_wready !== 1'b0 || if_a.o_level !== 6'd15) begin
            n_bad++; $display("FAIL one_read: wready=%b level=%0d want wready=0 level=15", if_a.o_wready, if_a.o_level);
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (if_a.o_wready !== 1'b1 || if_a.o_level !== 6'd12) begin
            n_bad++; $display("FAIL four_reads: wready=%b level=%0d want wready=1 level=12", if_a.o_wready, if_a.o_level);
        end
        drive(0, 1'b0, 64'd0, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic test_narrow_to_wide();
        logic [31:0] exp;
        exp = MSB_FIRST ? 32'hAABBCCDD : 32'hDDCCBBAA;
        @(negedge clk);
        drive(1, 1'b1, 64'hAA, 1'b1, 1'b0);
        @(negedge clk);
        drive(1, 1'b1, 64'hBB, 1'b1, 1'b0);
        @(negedge clk);
        drive(1, 1'b1, 64'hCC, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++; if (if_b.o_rvalid !== 1'b0 || if_b.o_level !== 4'd3) begin
            n_bad++; $display("FAIL n2w_partial: v=%b level=%0d want v=0 level=3", if_b.o_rvalid, if_b.o_level);
        end
        drive(1, 1'b1, 64'hDD, 1'b1, 1'b0);
        @(negedge clk);
        drive(1, 1'b0, 64'd0, 1'b1, 1'b0);
        n_cmp++; if (if_b.o_rvalid !== 1'b0 || if_b.o_level !== 4'd4) begin
            n_bad++; $display("FAIL n2w_written: v=%b level=%0d want v=0 level=4", if_b.o_rvalid, if_b.o_level);
        end
        @(negedge clk);
        n_cmp++; if (if_b.o_rvalid !== 1'b1 || if_b.o_rdata !== exp || if_b.o_level !== 4'd4) begin
            n_bad++; $display("FAIL n2w_word: v=%b d=%0h level=%0d want v=1 d=%0h level=4", if_b.o_rvalid, if_b.o_rdata, if_b.o_level, exp);
        end
        @(negedge clk);
        n_cmp++; if (if_b.o_rvalid !== 1'b0 || if_b.o_level !== 4'd0) begin
            n_bad++; $display("FAIL n2w_drained: v=%b level=%0d want v=0 level=0", if_b.o_rvalid, if_b.o_level);
        end
        drive(1, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic test_random(input int sel, input int nw, input bit incr);
        logic [63:0] lvl, rd, wd;
        logic        wrdy, rv, drop;
        bit          wv, rr;
        int          sent, cyc, rd_cnt;
        @(negedge clk);
        drive(sel, 1'b0, 64'd0, 1'b0, 1'b1);
        @(negedge clk);
        drive(sel, 1'b0, 64'd0, 1'b0, 1'b0);
        m_clear(sel);
        sent = 0; cyc = 0; rd_cnt = 0;
        while ((sent < nw || m_level() != 0) && cyc < 4000) begin
            sample(sel, lvl, wrdy, rv, rd, drop);
            n_cmp++; if (lvl !== 64'(m_level())) begin n_bad++; $display("FAIL rnd%0d_level c%0d: got %0d want %0d", sel, cyc, lvl, m_level()); end
            n_cmp++; if (wrdy !== m_wready()) begin n_bad++; $display("FAIL rnd%0d_wready c%0d: got %b want %b", sel, cyc, wrdy, m_wready()); end
            n_cmp++; if (rv !== m_held) begin n_bad++; $display("FAIL rnd%0d_rvalid c%0d: got %b want %b", sel, cyc, rv, m_held); end
            n_cmp++; if (drop !== m_drop) begin n_bad++; $display("FAIL rnd%0d_drop c%0d: got %b want %b", sel, cyc, drop, m_drop); end
            if (m_held) begin
                n_cmp++; if (rd !== m_word) begin n_bad++; $display("FAIL rnd%0d_rdata c%0d: got %0h want %0h", sel, cyc, rd, m_word); end
            end
            wv = (sent < nw) && ($urandom_range(0, 3) != 0);
            rr = (sent >= nw) ? 1'b1 : 1'($urandom_range(0, 1));
            wd = incr ? 64'(sent + 1) : {$urandom, $urandom};
            if (wv && m_wready()) sent++;
            if (m_held && rr) rd_cnt++;
            m_step(wv, wd, rr);
            drive(sel, wv, wd, rr, 1'b0);
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (cyc >= 4000) begin n_bad++; $display("FAIL rnd%0d_timeout: sent %0d level %0d", sel, sent, m_level()); end
        n_cmp++; if (rd_cnt != nw * m_wr / m_rr) begin
            n_bad++; $display("FAIL rnd%0d_words: got %0d want %0d", sel, rd_cnt, nw * m_wr / m_rr);
        end
        drive(sel, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive(0, 1'b1, 64'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 64'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 64'h5A5A5A5A, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (if_a.o_level !== 6'd0 || if_a.o_rvalid !== 1'b0 || if_a.o_wr_drop !== 1'b0 || if_a.o_wready !== 1'b1) begin
            n_bad++; $display("FAIL flush_state: level=%0d v=%b drop=%b wready=%b want 0/0/0/1",
                              if_a.o_level, if_a.o_rvalid, if_a.o_wr_drop, if_a.o_wready);
        end
        drive(0, 1'b0, 64'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (if_a.o_rvalid !== 1'b0 || if_a.o_level !== 6'd0 || if_a.o_wr_drop !== 1'b0) begin
                n_bad++; $display("FAIL flush_after%0d: v=%b level=%0d drop=%b want 0/0/0", i, if_a.o_rvalid, if_a.o_level, if_a.o_wr_drop);
            end
        end
        drive(0, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(0, 1'b1, 64'($urandom), 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 64'($urandom), 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (if_a.o_level !== 6'd0 || if_a.o_rvalid !== 1'b0 || if_a.o_rdata !== 8'd0 ||
                     if_a.o_wr_drop !== 1'b0 || if_a.o_wready !== 1'b1) begin
            n_bad++; $display("FAIL arst_immediate: level=%0d v=%b d=%0h drop=%b wready=%b want 0/0/0/0/1",
                              if_a.o_level, if_a.o_rvalid, if_a.o_rdata, if_a.o_wr_drop, if_a.o_wready);
        end
        @(negedge clk);
        drive(0, 1'b0, 64'd0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (if_a.o_level !== 6'd0 || if_a.o_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL arst_release: level=%0d v=%b want 0/0", if_a.o_level, if_a.o_rvalid);
        end
        drive(0, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 64'd0, 1'b0, 1'b0);
        test_reset();
        test_wide_to_narrow();
        test_full_drop();
        test_narrow_to_wide();
        test_random(0, 40, 1'b0);
        test_random(1, 60, 1'b0);
        test_random(2, 100, 1'b1);
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
